// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-addressed memory port.
// Handles lane steering, write masks, load extension and alignment faults.
module load_store_unit #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_error,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rstrb,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

   state_t                state_q, state_d;
   logic                  write_q, write_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            lsb_q, lsb_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_error_q, rsp_error_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_rstrb_q, mem_rstrb_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wmask_q, mem_wmask_d;

   logic                  req_error;
   logic [3:0]            st_mask;
   logic [31:0]           st_data;
   logic [31:0]           shifted;
   logic                  ld_signed;
   logic [31:0]           load_data;

   // The error-response cycle also blocks acceptance.
   assign req_ready = resetn & (state_q == S_IDLE) & ~rsp_error_q;

   always_comb begin
      req_error = 1'b0;
      case (req_funct3)
         3'd0:    req_error = 1'b0;
         3'd1:    req_error = req_addr[0];
         3'd2:    req_error = |req_addr[1:0];
         3'd4:    req_error = req_write;
         3'd5:    req_error = req_write | req_addr[0];
         default: req_error = 1'b1;
      endcase
   end

   always_comb begin
      st_mask = 4'b1111;
      st_data = req_wdata;
      case (req_funct3[1:0])
         2'd0: begin
            st_mask = 4'b0001 << req_addr[1:0];
            st_data = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            st_mask = 4'b0011 << {req_addr[1], 1'b0};
            st_data = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted   = mem_rdata >> {lsb_q, 3'b000};
   assign ld_signed = ~funct3_q[2];

   always_comb begin
      case (funct3_q[1:0])
         2'd0:    load_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
         2'd1:    load_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      funct3_d    = funct3_q;
      lsb_d       = lsb_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = '0;
      mem_addr_d  = mem_addr_q;
      mem_rstrb_d = 1'b0;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = '0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               if (req_error) begin
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
               end else begin
                  state_d    = S_ACCESS;
                  write_d    = req_write;
                  funct3_d   = req_funct3;
                  lsb_d      = req_addr[1:0];
                  mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  if (req_write) begin
                     mem_wmask_d = st_mask;
                     mem_wdata_d = st_data;
                  end else begin
                     mem_rstrb_d = 1'b1;
                  end
               end
            end
         end
         S_ACCESS: begin
            if (write_q) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = CNT_INIT;
            end
         end
         S_WAIT: begin
            // Read data is only trusted in the final wait cycle.
            if (cnt_q == '0) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_data;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         funct3_q    <= '0;
         lsb_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_rstrb_q <= 1'b0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         funct3_q    <= funct3_d;
         lsb_q       <= lsb_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_rstrb_q <= mem_rstrb_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_error = rsp_error_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rstrb = mem_rstrb_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Two instances (read latency 1 and 3) share one request stream; a reference
// memory predicts responses, which a separate monitor compares per instance.
module tb_load_store_unit;

   localparam int NDUT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        req_ready [NDUT];
   logic        rsp_valid [NDUT];
   logic        rsp_error [NDUT];
   logic [31:0] rsp_rdata [NDUT];
   logic [31:0] mem_addr  [NDUT];
   logic        mem_rstrb [NDUT];
   logic [31:0] mem_wdata [NDUT];
   logic [3:0]  mem_wmask [NDUT];
   logic [31:0] mem_rdata [NDUT];

   generate
      for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
         load_store_unit #(
            .READ_LATENCY (gi == 0 ? 1 : 3),
            .ADDR_WIDTH   (32)
         ) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .req_valid  (req_valid),
            .req_ready  (req_ready[gi]),
            .req_write  (req_write),
            .req_funct3 (req_funct3),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid[gi]),
            .rsp_rdata  (rsp_rdata[gi]),
            .rsp_error  (rsp_error[gi]),
            .mem_addr   (mem_addr[gi]),
            .mem_rstrb  (mem_rstrb[gi]),
            .mem_wdata  (mem_wdata[gi]),
            .mem_wmask  (mem_wmask[gi]),
            .mem_rdata  (mem_rdata[gi])
         );
      end
   endgenerate

   typedef struct {
      bit          err;
      bit          load;
      logic [31:0] rdata;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic [31:0] addr;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        exp_q [NDUT][$];
   logic [31:0] ref_mem [256];
   logic [31:0] sim_mem [NDUT][256];
   logic        mem_load;
   int          pend_cnt [NDUT];
   logic [7:0]  pend_idx [NDUT];
   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;

   function automatic int rl(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Memory model: registered read data appears READ_LATENCY cycles after the
   // strobe; intermediate cycles carry junk that must not be sampled.
   always @(posedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         if (mem_load) begin
            for (int i = 0; i < 256; i++) sim_mem[k][i] <= ref_mem[i];
            pend_cnt[k]  <= 0;
            mem_rdata[k] <= '0;
         end else begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask[k][b]) sim_mem[k][mem_addr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
            if (mem_rstrb[k]) begin
               pend_cnt[k] <= rl(k) - 1;
               pend_idx[k] <= mem_addr[k][9:2];
               if (rl(k) == 1) mem_rdata[k] <= sim_mem[k][mem_addr[k][9:2]];
            end else if (pend_cnt[k] > 0) begin
               pend_cnt[k] <= pend_cnt[k] - 1;
               if (pend_cnt[k] == 1) mem_rdata[k] <= sim_mem[k][pend_idx[k]];
               else                  mem_rdata[k] <= $urandom;
            end
         end
      end
   end

   function automatic bit is_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
      int nb;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (w && f3 >= 3'd4) return 1'b1;
      nb = 1 << f3[1:0];
      return (a % nb) != 0;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int nb, bits;
      nb   = 1 << f3[1:0];
      bits = 8 * nb;
      v    = ref_mem[a[9:2]] >> (8 * (a % 4));
      if (nb < 4) begin
         v = v & ((32'd1 << bits) - 32'd1);
         if (f3 < 3'd4 && v[bits-1]) v = v | ~((32'd1 << bits) - 32'd1);
      end
      return v;
   endfunction

   task automatic wait_ready(output bit ok);
      int t;
      t = 0;
      while (!(req_ready[0] && req_ready[1]) && t < 100) begin
         @(negedge clk);
         t++;
      end
      ok = (t < 100);
   endtask

   task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      bit   ok;
      int   nb;
      wait_ready(ok);
      if (!ok) begin
         fail_now("ready_wait");
         return;
      end
      nb      = 1 << f3[1:0];
      e.err   = is_err(w, f3, a);
      e.load  = !w;
      e.rdata = (e.err || w) ? 32'd0 : load_val(f3, a);
      e.mask  = 4'(((1 << nb) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(wd >> (8 * (i % nb)));
      e.addr  = {a[31:2], 2'b00};
      e.acc   = cyc;
      for (int k = 0; k < NDUT; k++) begin
         e.lat = e.err ? 1 : (w ? 2 : 2 + rl(k));
         exp_q[k].push_back(e);
      end
      if (!e.err && w)
         for (int i = 0; i < 4; i++)
            if (e.mask[i]) ref_mem[a[9:2]][8*i +: 8] = e.wdata[8*i +: 8];
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(negedge clk);
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d_ready_after_accept", k), 32'(req_ready[k]), 32'd0);
   endtask

   // Asserts reset ncyc cycles after an accept; the request must vanish.
   task automatic reset_mid(input bit w, input int ncyc);
      bit ok;
      wait_ready(ok);
      if (!ok) begin
         fail_now("reset_ready_wait");
         return;
      end
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = 3'd2;
      req_addr   = 32'h0000_0040;
      req_wdata  = $urandom;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (ncyc - 1) @(negedge clk);
      resetn = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("dut%0d_rst_rstrb", k), 32'(mem_rstrb[k]), 32'd0);
         chk($sformatf("dut%0d_rst_wmask", k), 32'(mem_wmask[k]), 32'd0);
         chk($sformatf("dut%0d_rst_rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
         chk($sformatf("dut%0d_rst_ready", k), 32'(req_ready[k]), 32'd0);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d_rel_ready", k), 32'(req_ready[k]), 32'd1);
      repeat (6) @(negedge clk);
      issue(1'b1, 3'd2, 32'h0000_0300, $urandom);
   endtask

   // Monitor: tallies memory activity per transaction and checks each response.
   initial begin
      int          rs_cnt [NDUT];
      int          wm_cnt [NDUT];
      logic [31:0] seen_addr [NDUT];
      logic [3:0]  seen_mask [NDUT];
      logic [31:0] seen_wdata [NDUT];
      exp_t        e;
      for (int k = 0; k < NDUT; k++) begin
         rs_cnt[k] = 0;
         wm_cnt[k] = 0;
         seen_addr[k] = '0;
         seen_mask[k] = '0;
         seen_wdata[k] = '0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            if (!resetn) begin
               rs_cnt[k] = 0;
               wm_cnt[k] = 0;
            end else begin
               if (mem_rstrb[k]) begin
                  rs_cnt[k]++;
                  seen_addr[k] = mem_addr[k];
               end
               if (mem_wmask[k] != 4'd0) begin
                  wm_cnt[k]++;
                  seen_addr[k]  = mem_addr[k];
                  seen_mask[k]  = mem_wmask[k];
                  seen_wdata[k] = mem_wdata[k];
               end
               if (rsp_valid[k]) begin
                  if (exp_q[k].size() == 0) begin
                     fail_now($sformatf("dut%0d_spurious_rsp", k));
                  end else begin
                     e = exp_q[k].pop_front();
                     chk($sformatf("dut%0d_latency", k), 32'(cyc - e.acc), 32'(e.lat));
                     chk($sformatf("dut%0d_error", k), 32'(rsp_error[k]), 32'(e.err));
                     chk($sformatf("dut%0d_rdata", k), rsp_rdata[k], e.rdata);
                     chk($sformatf("dut%0d_rstrb_pulses", k), 32'(rs_cnt[k]), (!e.err && e.load) ? 32'd1 : 32'd0);
                     chk($sformatf("dut%0d_wmask_cycles", k), 32'(wm_cnt[k]), (!e.err && !e.load) ? 32'd1 : 32'd0);
                     if (!e.err) chk($sformatf("dut%0d_mem_addr", k), seen_addr[k], e.addr);
                     if (!e.err && !e.load) begin
                        chk($sformatf("dut%0d_wmask", k), 32'(seen_mask[k]), 32'(e.mask));
                        chk($sformatf("dut%0d_wdata", k), seen_wdata[k], e.wdata);
                     end
                  end
                  rs_cnt[k] = 0;
                  wm_cnt[k] = 0;
               end
            end
         end
      end
   end

   initial begin
      bit          w;
      logic [2:0]  f3;
      logic [31:0] a;
      int          t;
      resetn     = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      ref_mem[8'h80] = 32'h80F1_7F01;
      mem_load = 1'b1;
      @(negedge clk);
      mem_load = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("dut%0d_reset_ready", k), 32'(req_ready[k]), 32'd0);
         chk($sformatf("dut%0d_reset_rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
         chk($sformatf("dut%0d_reset_rsp_error", k), 32'(rsp_error[k]), 32'd0);
         chk($sformatf("dut%0d_reset_rsp_rdata", k), rsp_rdata[k], 32'd0);
         chk($sformatf("dut%0d_reset_mem_addr", k), mem_addr[k], 32'd0);
         chk($sformatf("dut%0d_reset_rstrb", k), 32'(mem_rstrb[k]), 32'd0);
         chk($sformatf("dut%0d_reset_wmask", k), 32'(mem_wmask[k]), 32'd0);
         chk($sformatf("dut%0d_reset_wdata", k), mem_wdata[k], 32'd0);
      end
      resetn = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) chk($sformatf("dut%0d_ready_after_reset", k), 32'(req_ready[k]), 32'd1);
      @(negedge clk);

      issue(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
      issue(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5);
      issue(1'b1, 3'd1, 32'h0000_0102, 32'h0000_1234);
      issue(1'b0, 3'd0, 32'h0000_0200, 32'd0);
      issue(1'b0, 3'd0, 32'h0000_0203, 32'd0);
      issue(1'b0, 3'd4, 32'h0000_0203, 32'd0);
      issue(1'b0, 3'd1, 32'h0000_0202, 32'd0);
      issue(1'b0, 3'd5, 32'h0000_0202, 32'd0);
      issue(1'b0, 3'd2, 32'h0000_0200, 32'd0);
      issue(1'b0, 3'd2, 32'h0000_0201, 32'd0);
      issue(1'b1, 3'd1, 32'h0000_0101, 32'h1111_2222);
      issue(1'b1, 3'd4, 32'h0000_0100, 32'h3333_4444);
      issue(1'b0, 3'd3, 32'h0000_0100, 32'd0);
      issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);

      reset_mid(1'b0, 2);
      reset_mid(1'b0, 1);
      reset_mid(1'b1, 1);
      issue(1'b0, 3'd2, 32'h0000_0040, 32'd0);

      for (int n = 0; n < 300; n++) begin
         w = 1'($urandom);
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
         else begin
            case ($urandom_range(0, 4))
               0:       f3 = 3'd0;
               1:       f3 = 3'd1;
               2:       f3 = 3'd2;
               3:       f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            else if (f3[1:0] == 2'd1) a[0] = 1'b0;
         end
         issue(w, f3, a, $urandom);
         repeat ($urandom_range(0, 2) == 0 ? 1 : 0) @(negedge clk);
      end

      t = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("drain_dut0", 32'(exp_q[0].size()), 32'd0);
      chk("drain_dut1", 32'(exp_q[1].size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

endmodule
